adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the adder (2..8).
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port req_valid  input  NREQ  per-requester operation request.
REQ-005 Port req_a  input  32*NREQ  operand A; slice [32*i+31:32*i] belongs to requester i.
REQ-006 Port req_b  input  32*NREQ  operand B; same slicing as req_a.
REQ-007 Port req_ready  output  NREQ  one-hot accept strobe to the granted requester.
REQ-008 Port rsp_valid  output  1  result available.
REQ-009 Port rsp_ready  input  1  consumer accepts result.
REQ-010 Port rsp_id  output  clog2(NREQ)  index of the requester owning the result.
REQ-011 Port rsp_data  output  32  sum, modulo 2^32.
REQ-012 Port rsp_carry  output  1  bit 32 of the unsigned sum.
REQ-013 Port busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The block SHALL contain exactly one 32-bit adder, time-shared across all requesters.
REQ-015 The FSM SHALL have states IDLE, ADD and RESP, encoded in 2 bits.
REQ-016 In IDLE with any req_valid high, the block SHALL grant one winner w: the first set bit at or after ptr, scanning upward and wrapping from NREQ-1 to 0.
REQ-017 In that grant cycle, req_ready[w] SHALL be high combinationally, and all other req_ready bits SHALL be low.
REQ-018 At that clock edge, the block SHALL latch req_a[w], req_b[w] and w, then move to ADD.
REQ-019 req_ready SHALL be all-zero in ADD, in RESP, and in IDLE with no req_valid.
REQ-020 In ADD, the block SHALL register the 33-bit unsigned sum {carry, a+b} into rsp_carry/rsp_data and w into rsp_id, then move to RESP.
REQ-021 In RESP, rsp_valid SHALL be high.
REQ-022 While in RESP, rsp_data, rsp_carry and rsp_id SHALL stay stable until rsp_ready is sampled high.
REQ-023 On a RESP cycle with rsp_ready high, the block SHALL move to IDLE, clear rsp_valid, and set ptr to (w+1) mod NREQ.
REQ-024 Latency SHALL be: grant edge, then rsp_valid high 2 cycles after the grant cycle.
REQ-025 Peak throughput SHALL be one operation per 3 cycles; there is no grant in the cycle that rsp_ready is accepted.
REQ-026 A requester SHALL hold req_valid and its operands until it sees req_ready.
REQ-027 Deasserting req_valid before the grant SHALL withdraw the request with no side effects.
REQ-028 Operand changes on non-granted requesters SHALL never affect an in-flight result.
REQ-029 ptr SHALL change only on response acceptance; a withdrawn or unserved request SHALL not move it.
REQ-030 With all NREQ requesters continuously valid, each SHALL be served exactly once in every NREQ consecutive operations.
REQ-031 rsp_data and rsp_carry SHALL retain their last value after acceptance, until the next ADD.

Reset
REQ-032 While rst is high, the block SHALL force the following, independent of clk:
- state IDLE, ptr 0;
- rsp_valid 0, rsp_data 0, rsp_carry 0, rsp_id 0;
- busy 0, req_ready all-zero.
REQ-033 Reset asserted in ADD or RESP SHALL discard the in-flight operation with no response.
REQ-034 On the first edge after rst deasserts, the block SHALL resume normal arbitration from ptr 0.

Verification
REQ-035 Single request: req_valid=0001, a0=5, b0=7 -> req_ready=0001 in the grant cycle; 2 cycles later rsp_valid=1, rsp_data=12, rsp_carry=0, rsp_id=0.
REQ-036 Overflow: a=0xFFFFFFFF, b=0x00000002 -> rsp_data=0x00000001, rsp_carry=1.
REQ-037 Round-robin fairness: req_valid=1111 held, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1,… with no requester skipped.
REQ-038 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable; req_ready=0000; busy=1; only the cycle with rsp_ready=1 returns the block to IDLE.
REQ-039 Reset mid-operation: assert rst in ADD -> outputs zero immediately, no response is produced, the next request from requester 2 alone gets rsp_id=2 and ptr follows from 0.
REQ-040 Priority wrap: ptr=3 (after serving 2), req_valid=0011 -> requester 0 is granted, then requester 1.

Source files
------------

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one 32-bit adder across NREQ
// requesters. One operation per grant -> add -> response sequence.
module adder_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [32*NREQ-1:0]       req_a,
  input  logic [32*NREQ-1:0]       req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [31:0]              rsp_data,
  output logic                     rsp_carry,
  output logic                     busy
);

  localparam int unsigned DW = 32;
  localparam int unsigned IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_w;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;

  logic            w_found;
  logic [IW-1:0]   w_win;
  int unsigned     w_idx;
  logic [DW-1:0]   w_a;
  logic [DW-1:0]   w_b;
  logic [DW:0]     w_sum;

  // Round-robin scan: first valid requester at or after r_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = (32'(r_ptr) + k) % NREQ;
      if (!w_found && req_valid[IW'(w_idx)]) begin
        w_found = 1'b1;
        w_win   = IW'(w_idx);
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (IW'(k) == w_win) begin
        w_a = req_a[k*DW +: DW];
        w_b = req_b[k*DW +: DW];
      end
    end
  end

  // The single shared adder, operating on latched operands only.
  assign w_sum = {1'b0, r_a} + {1'b0, r_b};

  // One-hot accept strobe, only in an IDLE grant cycle and never under reset.
  always_comb begin
    req_ready = '0;
    if (!rst && (r_state == S_IDLE) && w_found) begin
      req_ready[w_win] = 1'b1;
    end
  end

  assign busy = (r_state != S_IDLE);

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_w       <= '0;
      r_a       <= '0;
      r_b       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_id    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_a     <= w_a;
            r_b     <= w_b;
            r_w     <= w_win;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          {rsp_carry, rsp_data} <= w_sum;
          rsp_id                <= r_w;
          rsp_valid             <= 1'b1;
          r_state               <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
            r_ptr     <= (32'(r_w) == NREQ - 1) ? '0 : IW'(r_w + 1'b1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed scenario tests for adder_arbiter (NREQ=4).
module tb_adder_arbiter;

  localparam int unsigned NREQ = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    req_valid = '0;
  logic [127:0]  req_a = '0;
  logic [127:0]  req_b = '0;
  logic [3:0]    req_ready;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_data;
  logic          rsp_carry;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  adder_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_vec++; if (rsp_data !== 32'd0) begin n_err++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    n_vec++; if (rsp_carry !== 1'b0) begin n_err++; $display("FAIL reset_rsp_carry got=%b exp=0", rsp_carry); end
    n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    tick();
    tick();
    n_vec++; if (req_ready !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL reset_held req_ready=%b busy=%b exp 0000/0", req_ready, busy); end
    req_valid = 4'b0000;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single();
    set_op(0, 32'd5, 32'd7);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant req_ready got=%b exp=0001", req_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    tick();
    req_valid = 4'b0000;
    #1;
    n_vec++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin n_err++; $display("FAIL single_add busy=%b rsp_valid=%b req_ready=%b exp 1/0/0000", busy, rsp_valid, req_ready); end
    tick();
    n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
    n_vec++; if (rsp_data !== 32'd12 || rsp_carry !== 1'b0) begin n_err++; $display("FAIL single_sum got=%0d c=%b exp=12 c=0", rsp_data, rsp_carry); end
    n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL single_id got=%0d exp=0", rsp_id); end
    tick();
    n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_accept rsp_valid=%b busy=%b exp 0/0", rsp_valid, busy); end
    n_vec++; if (rsp_data !== 32'd12) begin n_err++; $display("FAIL single_retain rsp_data got=%0d exp=12", rsp_data); end
  endtask

  task automatic test_overflow();
    set_op(1, 32'hFFFF_FFFF, 32'h0000_0002);
    req_valid = 4'b0010;
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL ovf_grant req_ready got=%b exp=0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    tick();
    n_vec++; if (rsp_data !== 32'h0000_0001 || rsp_carry !== 1'b1) begin n_err++; $display("FAIL ovf_sum got=%h c=%b exp=00000001 c=1", rsp_data, rsp_carry); end
    n_vec++; if (rsp_id !== 2'd1) begin n_err++; $display("FAIL ovf_id got=%0d exp=1", rsp_id); end
    tick();
  endtask

  task automatic test_backpressure();
    set_op(2, 32'd10, 32'd20);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_grant req_ready got=%b exp=0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    set_op(2, 32'hDEAD_BEEF, 32'h1234_5678);
    set_op(0, 32'd99, 32'd99);
    tick();
    req_valid = 4'b1011;
    #1;
    for (int c = 0; c < 5; c++) begin
      n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd30 || rsp_id !== 2'd2) begin n_err++; $display("FAIL bp_hold[%0d] valid=%b data=%0d id=%0d exp 1/30/2", c, rsp_valid, rsp_data, rsp_id); end
      n_vec++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin n_err++; $display("FAIL bp_ctrl[%0d] req_ready=%b busy=%b exp 0000/1", c, req_ready, busy); end
      tick();
    end
    rsp_ready = 1'b1;
    req_valid = 4'b0000;
    #1;
    n_vec++; if (rsp_valid !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL bp_last valid=%b busy=%b exp 1/1", rsp_valid, busy); end
    tick();
    n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL bp_release valid=%b busy=%b exp 0/0", rsp_valid, busy); end
  endtask

  task automatic test_prio_wrap();
    set_op(0, 32'd1, 32'd2);
    set_op(1, 32'd3, 32'd4);
    req_valid = 4'b0011;
    rsp_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL wrap_grant0 req_ready got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'b0010;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL wrap_add_ready got=%b exp=0000", req_ready); end
    tick();
    n_vec++; if (rsp_id !== 2'd0 || rsp_data !== 32'd3) begin n_err++; $display("FAIL wrap_rsp0 id=%0d data=%0d exp 0/3", rsp_id, rsp_data); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL wrap_resp_ready got=%b exp=0000", req_ready); end
    tick();
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL wrap_grant1 req_ready got=%b exp=0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    tick();
    n_vec++; if (rsp_id !== 2'd1 || rsp_data !== 32'd7) begin n_err++; $display("FAIL wrap_rsp1 id=%0d data=%0d exp 1/7", rsp_id, rsp_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    set_op(3, 32'd50, 32'd60);
    req_valid = 4'b1000;
    #1;
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rmid_grant req_ready got=%b exp=1000", req_ready); end
    tick();
    req_valid = 4'b0000;
    #1;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_add_busy got=%b exp=1", busy); end
    rst = 1'b1;
    #1;
    n_vec++; if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_carry !== 1'b0 || rsp_id !== 2'd0) begin n_err++; $display("FAIL rmid_outputs valid=%b data=%h c=%b id=%0d exp all 0", rsp_valid, rsp_data, rsp_carry, rsp_id); end
    n_vec++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin n_err++; $display("FAIL rmid_ctrl busy=%b req_ready=%b exp 0/0000", busy, req_ready); end
    tick();
    rst = 1'b0;
    set_op(1, 32'd0, 32'd0);
    set_op(2, 32'd7, 32'd8);
    req_valid = 4'b0110;
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rmid_ptr0 req_ready got=%b exp=0010", req_ready); end
    req_valid = 4'b0100;
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rmid_withdraw req_ready got=%b exp=0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    #1;
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rmid_no_rsp valid got=%b exp=0", rsp_valid); end
    tick();
    n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'd15 || rsp_carry !== 1'b0) begin n_err++; $display("FAIL rmid_rsp valid=%b id=%0d data=%0d c=%b exp 1/2/15/0", rsp_valid, rsp_id, rsp_data, rsp_carry); end
    tick();
  endtask

  task automatic test_fairness();
    int unsigned exp_id;
    logic [3:0]  exp_rr;
    for (int i = 0; i < 4; i++) set_op(i, 32'(i * 16 + 1), 32'd1000);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      exp_id = (3 + n) % 4;
      exp_rr = 4'd1 << exp_id;
      #1;
      n_vec++; if (req_ready !== exp_rr) begin n_err++; $display("FAIL rr_grant[%0d] req_ready got=%b exp=%b", n, req_ready, exp_rr); end
      tick();
      tick();
      n_vec++; if (rsp_id !== 2'(exp_id) || rsp_data !== 32'(exp_id * 16 + 1001)) begin n_err++; $display("FAIL rr_rsp[%0d] id=%0d data=%0d exp %0d/%0d", n, rsp_id, rsp_data, exp_id, exp_id * 16 + 1001); end
      tick();
    end
    req_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_backpressure();
    test_prio_wrap();
    test_reset_mid();
    test_fairness();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
